// File: rtl/sp_ram_bank_arb.sv
// Two-master round-robin front end for the single-port SRAM bank: combinational grant,
// one-cycle registered response routing, out-of-range accesses completed without the macro.

module sp_ram_bank_arb_resp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  own_i,
  input  logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  assign rvalid_o = own_i;
  assign rdata_o  = (own_i && rd_i) ? mem_rdata_i : '0;
endmodule

module sp_ram_bank_arb #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_WORDS = 16384
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    a_req_i,
  output logic                    a_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  output logic                    a_rvalid_o,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  input  logic                    b_req_i,
  output logic                    b_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  output logic                    b_rvalid_o,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int          NP     = 2;
  localparam int          BEW    = DATA_WIDTH / 8;
  localparam logic [31:0] WORDS_U = BANK_WORDS;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BEW-1:0]        be;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t [NP-1:0]                 req_pl;
  req_t                          sel;
  logic [NP-1:0]                 req, gnt, resp_own, rvalid;
  logic [NP-1:0][DATA_WIDTH-1:0] rdata;
  logic [31:0]                   widx;
  logic                          in_range;
  logic                          rr_last_q;  // 1 = B was granted last
  logic                          resp_vld_q, resp_port_q, resp_rd_q;

  assign req       = {b_req_i, a_req_i};
  assign req_pl[0] = '{addr: a_addr_i, we: a_we_i, be: a_be_i, wdata: a_wdata_i};
  assign req_pl[1] = '{addr: b_addr_i, we: b_we_i, be: b_be_i, wdata: b_wdata_i};

  always_comb begin
    gnt = '0;
    if (rstn_i) begin
      if (req[0] && (!req[1] || rr_last_q)) gnt[0] = 1'b1;
      else if (req[1])                      gnt[1] = 1'b1;
    end
  end

  // Payload defaults to port A whenever B is not the winner.
  assign sel      = gnt[1] ? req_pl[1] : req_pl[0];
  assign widx     = 32'(sel.addr[ADDR_WIDTH-1:2]);
  assign in_range = widx < WORDS_U;

  assign a_gnt_o     = gnt[0];
  assign b_gnt_o     = gnt[1];
  assign mem_en_o    = (|gnt) && in_range;
  assign mem_addr_o  = sel.addr;
  assign mem_we_o    = sel.we;
  assign mem_be_o    = sel.be;
  assign mem_wdata_o = sel.wdata;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_vld_q  <= 1'b0;
      resp_port_q <= 1'b0;
      resp_rd_q   <= 1'b0;
      rr_last_q   <= 1'b1;
    end else begin
      resp_vld_q <= |gnt;
      if (|gnt) begin
        resp_port_q <= gnt[1];
        resp_rd_q   <= in_range && !sel.we;
        rr_last_q   <= gnt[1];
      end
    end
  end

  assign resp_own = resp_vld_q ? {resp_port_q, !resp_port_q} : '0;

  for (genvar i = 0; i < NP; i++) begin : g_resp
    sp_ram_bank_arb_resp #(.DATA_WIDTH(DATA_WIDTH)) u_resp (
      .own_i       (resp_own[i]),
      .rd_i        (resp_rd_q),
      .mem_rdata_i (mem_rdata_i),
      .rvalid_o    (rvalid[i]),
      .rdata_o     (rdata[i])
    );
  end

  assign a_rvalid_o = rvalid[0];
  assign a_rdata_o  = rdata[0];
  assign b_rvalid_o = rvalid[1];
  assign b_rdata_o  = rdata[1];
endmodule

// File: tb/tb_sp_ram_bank_arb.sv
// Directed bench for sp_ram_bank_arb with a behavioural one-cycle-latency bank behind it.

module tb_sp_ram_bank_arb;
  localparam int AW = 17;
  localparam int DW = 32;

  logic          clk, rstn;
  logic          a_req, a_gnt, a_we, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [3:0]    a_be;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_gnt, b_we, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [3:0]    b_be;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  sp_ram_bank_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_WORDS(16384)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .a_req_i(a_req), .a_gnt_o(a_gnt), .a_addr_i(a_addr), .a_we_i(a_we), .a_be_i(a_be),
    .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_gnt_o(b_gnt), .b_addr_i(b_addr), .b_we_i(b_we), .b_be_i(b_be),
    .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: registered read, byte-masked write, plus a preload port.
  logic [DW-1:0] bank [0:32767];
  logic [DW-1:0] bank_rd_q;
  logic          pre_en;
  logic [14:0]   pre_idx;
  logic [DW-1:0] pre_data;
  assign mem_rdata = bank_rd_q;

  always @(posedge clk) begin
    if (pre_en) bank[pre_idx] <= pre_data;
    else if (mem_en) begin
      if (mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_be[k]) bank[mem_addr[16:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
      end else bank_rd_q <= bank[mem_addr[16:2]];
    end
  end

  typedef struct {
    logic          a_req; logic [AW-1:0] a_addr; logic a_we; logic [3:0] a_be; logic [DW-1:0] a_wd;
    logic          b_req; logic [AW-1:0] b_addr; logic b_we; logic [3:0] b_be; logic [DW-1:0] b_wd;
    logic          x_agnt, x_bgnt, x_en;
    logic [AW-1:0] x_maddr; logic [3:0] x_mbe;
    logic          x_arv; logic [DW-1:0] x_ard;
    logic          x_brv; logic [DW-1:0] x_brd;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_req = v.a_req; a_addr = v.a_addr; a_we = v.a_we; a_be = v.a_be; a_wdata = v.a_wd;
    b_req = v.b_req; b_addr = v.b_addr; b_we = v.b_we; b_be = v.b_be; b_wdata = v.b_wd;
  endtask

  task automatic idle();
    a_req = 0; a_addr = '0; a_we = 0; a_be = '0; a_wdata = '0;
    b_req = 0; b_addr = '0; b_we = 0; b_be = '0; b_wdata = '0;
  endtask

  task automatic preload(input int idx, input logic [DW-1:0] d);
    @(negedge clk);
    pre_en = 1; pre_idx = 15'(idx); pre_data = d;
    @(negedge clk);
    pre_en = 0;
  endtask

  function automatic vec_t mk(
      input logic ar, input logic [AW-1:0] aa, input logic aw, input logic [3:0] abe, input logic [DW-1:0] ad,
      input logic br, input logic [AW-1:0] ba, input logic bw, input logic [3:0] bbe, input logic [DW-1:0] bd,
      input logic xag, input logic xbg, input logic xen, input logic [AW-1:0] xma, input logic [3:0] xmbe,
      input logic xarv, input logic [DW-1:0] xard, input logic xbrv, input logic [DW-1:0] xbrd);
    vec_t v;
    v.a_req = ar; v.a_addr = aa; v.a_we = aw; v.a_be = abe; v.a_wd = ad;
    v.b_req = br; v.b_addr = ba; v.b_we = bw; v.b_be = bbe; v.b_wd = bd;
    v.x_agnt = xag; v.x_bgnt = xbg; v.x_en = xen; v.x_maddr = xma; v.x_mbe = xmbe;
    v.x_arv = xarv; v.x_ard = xard; v.x_brv = xbrv; v.x_brd = xbrd;
    return v;
  endfunction

  initial begin
    rstn = 0; pre_en = 0; pre_idx = '0; pre_data = '0;
    idle();
    // Vectors are applied one per cycle; rvalid/rdata columns are the response to the previous row.
    //            A: req addr     we be   wdata          B: req addr    we be    wdata          gA gB en maddr    mbe   rvA rdA           rvB rdB
    vecs[0]  = mk(1, 17'h00010, 0, 4'hF, 32'h0,          0, 17'h0,     0, 4'h0, 32'h0,          1, 0, 1, 17'h00010, 4'hF, 0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(0, 17'h0,     0, 4'h0, 32'h0,          1, 17'h00100, 1, 4'h5, 32'h11223344,   0, 1, 1, 17'h00100, 4'h5, 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[2]  = mk(0, 17'h0,     0, 4'h0, 32'h0,          1, 17'h00100, 0, 4'hF, 32'h0,          0, 1, 1, 17'h00100, 4'hF, 0, 32'h0,        1, 32'h0);
    vecs[3]  = mk(1, 17'h00020, 0, 4'hF, 32'h0,          1, 17'h00024, 0, 4'hF, 32'h0,          1, 0, 1, 17'h00020, 4'hF, 0, 32'h0,        1, 32'h00220044);
    vecs[4]  = mk(1, 17'h00020, 0, 4'hF, 32'h0,          1, 17'h00024, 0, 4'hF, 32'h0,          0, 1, 1, 17'h00024, 4'hF, 1, 32'hA0A0A0A0, 0, 32'h0);
    vecs[5]  = mk(1, 17'h00020, 0, 4'hF, 32'h0,          1, 17'h00024, 0, 4'hF, 32'h0,          1, 0, 1, 17'h00020, 4'hF, 0, 32'h0,        1, 32'hB0B0B0B0);
    vecs[6]  = mk(1, 17'h00020, 0, 4'hF, 32'h0,          1, 17'h00024, 0, 4'hF, 32'h0,          0, 1, 1, 17'h00024, 4'hF, 1, 32'hA0A0A0A0, 0, 32'h0);
    vecs[7]  = mk(0, 17'h0,     0, 4'h0, 32'h0,          0, 17'h0,     0, 4'h0, 32'h0,          0, 0, 0, 17'h00000, 4'h0, 0, 32'h0,        1, 32'hB0B0B0B0);
    vecs[8]  = mk(1, 17'h10000, 0, 4'hF, 32'h0,          0, 17'h0,     0, 4'h0, 32'h0,          1, 0, 0, 17'h10000, 4'hF, 0, 32'h0,        0, 32'h0);
    vecs[9]  = mk(1, 17'h10000, 1, 4'hF, 32'hFFFFFFFF,   0, 17'h0,     0, 4'h0, 32'h0,          1, 0, 0, 17'h10000, 4'hF, 1, 32'h0,        0, 32'h0);
    vecs[10] = mk(0, 17'h0,     0, 4'h0, 32'h0,          0, 17'h0,     0, 4'h0, 32'h0,          0, 0, 0, 17'h00000, 4'h0, 1, 32'h0,        0, 32'h0);
    vecs[11] = mk(1, 17'h00020, 1, 4'h0, 32'hFFFFFFFF,   0, 17'h0,     0, 4'h0, 32'h0,          1, 0, 1, 17'h00020, 4'h0, 0, 32'h0,        0, 32'h0);
    vecs[12] = mk(1, 17'h00020, 0, 4'hF, 32'h0,          0, 17'h0,     0, 4'h0, 32'h0,          1, 0, 1, 17'h00020, 4'hF, 1, 32'h0,        0, 32'h0);
    vecs[13] = mk(0, 17'h0,     0, 4'h0, 32'h0,          0, 17'h0,     0, 4'h0, 32'h0,          0, 0, 0, 17'h00000, 4'h0, 1, 32'hA0A0A0A0, 0, 32'h0);

    preload(4, 32'hDEADBEEF);
    preload(64, 32'h0);
    preload(8, 32'hA0A0A0A0);
    preload(9, 32'hB0B0B0B0);
    preload(16384, 32'h0);
    for (int i = 0; i < 8; i++) preload(16 + i, 32'h50000000 + i);

    // Reset state, with a request held to show the grant is forced low.
    @(negedge clk);
    a_req = 1; b_req = 1;
    #1;
    chk("rst_a_gnt", 64'(a_gnt), 64'd0);
    chk("rst_b_gnt", 64'(b_gnt), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_a_rvalid", 64'(a_rvalid), 64'd0);
    chk("rst_b_rvalid", 64'(b_rvalid), 64'd0);
    chk("rst_a_rdata", 64'(a_rdata), 64'd0);
    idle();
    @(negedge clk);
    rstn = 1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_a_gnt", i), 64'(a_gnt), 64'(vecs[i].x_agnt));
      chk($sformatf("v%0d_b_gnt", i), 64'(b_gnt), 64'(vecs[i].x_bgnt));
      chk($sformatf("v%0d_mem_en", i), 64'(mem_en), 64'(vecs[i].x_en));
      chk($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].x_maddr));
      chk($sformatf("v%0d_mem_be", i), 64'(mem_be), 64'(vecs[i].x_mbe));
      chk($sformatf("v%0d_a_rvalid", i), 64'(a_rvalid), 64'(vecs[i].x_arv));
      chk($sformatf("v%0d_a_rdata", i), 64'(a_rdata), 64'(vecs[i].x_ard));
      chk($sformatf("v%0d_b_rvalid", i), 64'(b_rvalid), 64'(vecs[i].x_brv));
      chk($sformatf("v%0d_b_rdata", i), 64'(b_rdata), 64'(vecs[i].x_brd));
    end
    chk("oor_write_dropped", 64'(bank[16384]), 64'd0);
    chk("be0_write_noop", 64'(bank[8]), 64'hA0A0A0A0);

    // A streams 8 back-to-back reads with B idle.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      idle();
      if (i < 8) begin
        a_req = 1; a_addr = 17'(32'h40 + 4 * i); a_be = 4'hF;
      end
      #1;
      chk($sformatf("s%0d_a_gnt", i), 64'(a_gnt), 64'(i < 8));
      chk($sformatf("s%0d_a_rvalid", i), 64'(a_rvalid), 64'(i > 0));
      if (i > 0) chk($sformatf("s%0d_a_rdata", i), 64'(a_rdata), 64'(32'h50000000 + i - 1));
    end

    // Reset in the cycle after a grant drops the response and restores A priority.
    @(negedge clk);
    idle(); a_req = 1; a_addr = 17'h10; a_be = 4'hF;
    #1;
    chk("r5_a_gnt", 64'(a_gnt), 64'd1);
    @(negedge clk);
    rstn = 0;
    #1;
    chk("r5_rst_a_gnt", 64'(a_gnt), 64'd0);
    chk("r5_rst_mem_en", 64'(mem_en), 64'd0);
    chk("r5_rst_a_rvalid", 64'(a_rvalid), 64'd0);
    @(negedge clk);
    idle(); rstn = 1;
    #1;
    chk("r5_rel_a_rvalid", 64'(a_rvalid), 64'd0);
    @(negedge clk);
    #1;
    chk("r5_idle_a_rvalid", 64'(a_rvalid), 64'd0);
    a_req = 1; a_addr = 17'h10; a_be = 4'hF;
    b_req = 1; b_addr = 17'h20; b_be = 4'hF;
    #1;
    chk("r5_contest_a_gnt", 64'(a_gnt), 64'd1);
    chk("r5_contest_b_gnt", 64'(b_gnt), 64'd0);
    @(negedge clk);
    idle();
    #1;
    chk("r5_after_a_rvalid", 64'(a_rvalid), 64'd1);
    chk("r5_after_a_rdata", 64'(a_rdata), 64'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
